tp_gerador: RTL and testbench
=============================

TP_GERADOR -- requirements
Module: tp_gerador

Interface
REQ-001 SHALL have parameter: HOLD_CICLOS, default 2, number of cycles nota/tom stay stable before and after each ok pulse (legal 1..15).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on posedge clk.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request to emit one word; sampled only in OCIOSO.
REQ-005 SHALL have port: tipo  input  2  word class to emit: 00 nulo, 01 adj, 10 comp, 11 adv.
REQ-006 SHALL have port: variante  input  1  third-note choice for adj/comp: 0 la (6), 1 si (7); ignored for adv and nulo.
REQ-007 SHALL have port: nota  output  3  note code: 0 x, 1 do, 2 re, 6 la, 7 si.
REQ-008 SHALL have port: tom  output  1  sharp flag accompanying nota.
REQ-009 SHALL have port: ok  output  1  one-cycle note strobe for the note-classifier receiver.
REQ-010 SHALL have port: ocupado  output  1  high from the cycle after start is accepted until fim.
REQ-011 SHALL have port: fim  output  1  one-cycle pulse after the last note of a word.
REQ-012 SHALL have port: display  output  7  present only under TP_GERADOR_DISPLAY_EN (see Configuration).

Function
REQ-013 SHALL latch tipo and variante on the accepting edge; later changes SHALL NOT affect the current word.
REQ-014 SHALL emit these sequences as (nota,tom): adj = (0,0),(0,0),(6 or 7,0),(0,0); comp/variante0 = (0,0),(0,0),(6,0),(1,1); comp/variante1 = (0,0),(0,0),(7,0),(2,1); adv = (0,0),(0,0),(6,0),(7,0); nulo = (0,0),(0,0),(1,0) (3 notes, forces receiver error).
REQ-015 SHALL implement states OCIOSO, PREP, PULSO, ESPERA, FIM with a note index (0..3) and a hold counter.
REQ-016 OCIOSO: start=1 -> PREP, index 0, nota/tom loaded with note 0 on the same edge; else stay.
REQ-017 PREP: ok=0, nota/tom stable; after HOLD_CICLOS cycles -> PULSO.
REQ-018 PULSO: ok=1 for exactly one cycle, nota/tom unchanged -> ESPERA.
REQ-019 ESPERA: ok=0, nota/tom unchanged for HOLD_CICLOS cycles; then if index is last -> FIM, else index+1, load next note, -> PREP.
REQ-020 FIM: fim=1, ocupado=0, ok=0 for one cycle -> OCIOSO; nota/tom keep last value until next accepted start.
REQ-021 Per-note length SHALL be 2*HOLD_CICLOS+1 cycles; with HOLD_CICLOS=2 a 4-note word SHALL assert fim exactly 21 cycles after the accepting edge, and ok SHALL be high at cycles 3, 8, 13, 18.
REQ-022 start while ocupado=1 or in FIM SHALL be ignored (no queueing).
REQ-023 ok SHALL never be high on two consecutive cycles, and nota/tom SHALL never change in a cycle where ok=1 or the cycle adjacent to it.

Reset
REQ-024 reset=1 SHALL force OCIOSO, nota=0, tom=0, ok=0, ocupado=0, fim=0, index=0, counter=0 on the next edge; display SHALL show 0.
REQ-025 reset SHALL win over start on the same edge; reset mid-word SHALL abort with no further ok and no fim.

Configuration
REQ-026 Macro TP_GERADOR_DISPLAY_EN defined: display port exists and is registered, active-high segments gfedcba, showing the decimal digit of nota while ocupado=1 and the digit of the latched tipo (0..3) while idle.
REQ-027 Macro TP_GERADOR_DISPLAY_EN undefined: display port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-028 HOLD_CICLOS=2, tipo=10, variante=0, start pulse -> ok at +3,+8,+13,+18 with (0,0),(0,0),(6,0),(1,1); fim at +21.
REQ-029 tipo=00, start -> three ok pulses with (0,0),(0,0),(1,0); fim at +16; receiver model reports error.
REQ-030 tipo=11 accepted, tipo driven to 01 and start re-pulsed mid-word -> emitted word still adv ending (7,0); second start ignored, single fim.
REQ-031 reset asserted the cycle after the second ok -> next cycle ok=0, ocupado=0, nota=0; no fim follows; new start afterwards emits a full word.
REQ-032 start and reset high on the same edge -> remains OCIOSO, ocupado=0.
REQ-033 Back-to-back: start held high continuously with tipo=01, variante=1 -> words separated by the OCIOSO cycle after fim; each word (0,0),(0,0),(7,0),(0,0).

Source files
------------

// File: rtl/tp_gerador.sv
// Note-word generator for the note-classifier receiver.
// Optional registered 7-segment display: define TP_GERADOR_DISPLAY_EN.
module tp_gerador #(
  parameter int unsigned HOLD_CICLOS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] tipo,
  input  logic       variante,
  output logic [2:0] nota,
  output logic       tom,
  output logic       ok,
  output logic       ocupado,
  output logic       fim
`ifdef TP_GERADOR_DISPLAY_EN
  ,
  output logic [6:0] display
`endif
);

  typedef enum logic [2:0] {OCIOSO, PREP, PULSO, ESPERA, FIM} estado_t;

  localparam logic [3:0] HOLD_FIM = 4'(HOLD_CICLOS - 1);

  estado_t    estado, estado_d;
  logic [1:0] idx, idx_d;
  logic [3:0] cnt, cnt_d;
  logic [1:0] tipo_q, tipo_d;
  logic       var_q, var_d;
  logic [2:0] nota_d;
  logic       tom_d;
  logic [1:0] ultimo;
  logic [1:0] idx_prox;

  // {nota, tom} for note i of the word selected by t/v
  function automatic logic [3:0] nota_de(input logic [1:0] t, input logic v,
                                         input logic [1:0] i);
    logic [3:0] r;
    r = '0;
    if (i == 2'd2) begin
      case (t)
        2'b00:   r = {3'd1, 1'b0};
        2'b11:   r = {3'd6, 1'b0};
        default: r = {(v ? 3'd7 : 3'd6), 1'b0};
      endcase
    end else if (i == 2'd3) begin
      case (t)
        2'b10:   r = v ? {3'd2, 1'b1} : {3'd1, 1'b1};
        2'b11:   r = {3'd7, 1'b0};
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  assign ultimo   = (tipo_q == 2'b00) ? 2'd2 : 2'd3;
  assign idx_prox = 2'(idx + 2'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      estado <= OCIOSO;
      idx    <= '0;
      cnt    <= '0;
      tipo_q <= '0;
      var_q  <= 1'b0;
      nota   <= '0;
      tom    <= 1'b0;
    end else begin
      estado <= estado_d;
      idx    <= idx_d;
      cnt    <= cnt_d;
      tipo_q <= tipo_d;
      var_q  <= var_d;
      nota   <= nota_d;
      tom    <= tom_d;
    end
  end

  always_comb begin
    estado_d = estado;
    idx_d    = idx;
    cnt_d    = cnt;
    tipo_d   = tipo_q;
    var_d    = var_q;
    nota_d   = nota;
    tom_d    = tom;
    ok       = 1'b0;
    fim      = 1'b0;
    ocupado  = 1'b0;
    case (estado)
      OCIOSO: begin
        if (start) begin
          estado_d        = PREP;
          idx_d           = '0;
          cnt_d           = '0;
          tipo_d          = tipo;
          var_d           = variante;
          {nota_d, tom_d} = nota_de(tipo, variante, 2'd0);
        end
      end
      PREP: begin
        ocupado = 1'b1;
        if (cnt == HOLD_FIM) begin
          cnt_d    = '0;
          estado_d = PULSO;
        end else begin
          cnt_d = 4'(cnt + 4'd1);
        end
      end
      PULSO: begin
        ocupado  = 1'b1;
        ok       = 1'b1;
        cnt_d    = '0;
        estado_d = ESPERA;
      end
      ESPERA: begin
        ocupado = 1'b1;
        if (cnt == HOLD_FIM) begin
          cnt_d = '0;
          if (idx == ultimo) begin
            estado_d = FIM;
          end else begin
            idx_d           = idx_prox;
            {nota_d, tom_d} = nota_de(tipo_q, var_q, idx_prox);
            estado_d        = PREP;
          end
        end else begin
          cnt_d = 4'(cnt + 4'd1);
        end
      end
      FIM: begin
        fim      = 1'b1;
        estado_d = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

`ifdef TP_GERADOR_DISPLAY_EN
  function automatic logic [6:0] seg(input logic [2:0] d);
    logic [6:0] s;
    case (d)
      3'd0:    s = 7'h3F;
      3'd1:    s = 7'h06;
      3'd2:    s = 7'h5B;
      3'd3:    s = 7'h4F;
      3'd4:    s = 7'h66;
      3'd5:    s = 7'h6D;
      3'd6:    s = 7'h7D;
      default: s = 7'h07;
    endcase
    return s;
  endfunction

  logic ocupado_d;
  assign ocupado_d = (estado_d == PREP) || (estado_d == PULSO) || (estado_d == ESPERA);

  // Driven from next-state values so the digit lines up with nota/ocupado
  always_ff @(posedge clk) begin
    if (reset) display <= seg(3'd0);
    else       display <= seg(ocupado_d ? nota_d : {1'b0, tipo_d});
  end
`endif

endmodule

// File: tb/tb_tp_gerador.sv
// Randomized scoreboard bench for tp_gerador: a word-level model queues
// expected ok/fim events by edge number; a monitor pops and compares.
module tb_tp_gerador;
  localparam int unsigned H = 2;
  localparam int unsigned P = 2 * H + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] tipo = '0;
  logic       variante = 1'b0;
  logic [2:0] nota;
  logic       tom, ok, ocupado, fim;
`ifdef TP_GERADOR_DISPLAY_EN
  logic [6:0] display;
`endif

  always #5 clk = ~clk;

  tp_gerador #(.HOLD_CICLOS(H)) dut (
    .clk(clk), .reset(reset), .start(start), .tipo(tipo), .variante(variante),
    .nota(nota), .tom(tom), .ok(ok), .ocupado(ocupado), .fim(fim)
`ifdef TP_GERADOR_DISPLAY_EN
    , .display(display)
`endif
  );

  typedef struct {
    int unsigned e;
    logic [2:0]  n;
    logic        t;
  } ev_t;

  ev_t         okq[$];
  int unsigned fimq[$];
  int unsigned edge_n = 0, cur_start = 0, cur_end = 0, free_edge = 0, reset_edge = 0;
  bit          armed = 0;
  int          checks = 0, errors = 0;
  logic        prev_ok = 1'b0;
  logic [2:0]  prev_nota = '0;
  logic        prev_tom = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_n, act, exp);
    end
  endtask

  // Word table: each entry is {nota, tom}
  task automatic word(input logic [1:0] tp, input logic vr, output int unsigned len,
                      output logic [3:0] seq [4]);
    seq[0] = 4'h0;
    seq[1] = 4'h0;
    seq[3] = 4'h0;
    len = 4;
    case (tp)
      2'b00: begin len = 3; seq[2] = {3'd1, 1'b0}; end
      2'b01: seq[2] = {(vr ? 3'd7 : 3'd6), 1'b0};
      2'b10: begin
        seq[2] = {(vr ? 3'd7 : 3'd6), 1'b0};
        seq[3] = vr ? {3'd2, 1'b1} : {3'd1, 1'b1};
      end
      default: begin seq[2] = {3'd6, 1'b0}; seq[3] = {3'd7, 1'b0}; end
    endcase
  endtask

  task automatic drive(input logic st, input logic [1:0] tp, input logic vr, input logic rst);
    int unsigned ee, len;
    logic [3:0]  seq [4];
    ev_t         ev;
    @(negedge clk);
    start = st; tipo = tp; variante = vr; reset = rst;
    ee = edge_n + 1;
    if (rst) begin
      armed = 1;
      while (okq.size() > 0 && okq[$].e >= ee) void'(okq.pop_back());
      while (fimq.size() > 0 && fimq[$] >= ee) void'(fimq.pop_back());
      if (cur_end > ee) cur_end = ee;
      free_edge  = ee + 1;
      reset_edge = ee;
    end else if (st && ee >= free_edge) begin
      word(tp, vr, len, seq);
      for (int unsigned k = 0; k < len; k++) begin
        ev.e = ee + H + P * k;
        ev.n = seq[k][3:1];
        ev.t = seq[k][0];
        okq.push_back(ev);
      end
      fimq.push_back(ee + P * len);
      cur_start = ee;
      cur_end   = ee + P * len;
      free_edge = cur_end + 2;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
  endtask

  always @(posedge clk) begin
    ev_t ev;
    #1;
    edge_n++;
    if (armed) begin
      if (edge_n == reset_edge) begin
        chk("reset_nota", 32'(nota), 32'd0);
        chk("reset_tom", 32'(tom), 32'd0);
        chk("reset_ok", 32'(ok), 32'd0);
        chk("reset_fim", 32'(fim), 32'd0);
      end
      chk("ocupado", 32'(ocupado), 32'(edge_n >= cur_start && edge_n < cur_end));
      while (okq.size() > 0 && okq[0].e < edge_n) begin
        checks++; errors++;
        $display("FAIL ok_missed at edge %0d: got no ok, expected ok at edge %0d", edge_n, okq[0].e);
        void'(okq.pop_front());
      end
      while (fimq.size() > 0 && fimq[0] < edge_n) begin
        checks++; errors++;
        $display("FAIL fim_missed at edge %0d: got no fim, expected fim at edge %0d", edge_n, fimq[0]);
        void'(fimq.pop_front());
      end
      if (ok) begin
        if (okq.size() == 0 || okq[0].e != edge_n) begin
          checks++; errors++;
          $display("FAIL ok_unexpected at edge %0d: got ok=1, expected ok=0", edge_n);
        end else begin
          ev = okq.pop_front();
          chk("ok_nota", 32'(nota), 32'(ev.n));
          chk("ok_tom", 32'(tom), 32'(ev.t));
        end
        chk("ok_consecutive", 32'(prev_ok), 32'd0);
        chk("hold_into_ok", 32'({nota, tom}), 32'({prev_nota, prev_tom}));
      end
      if (fim) begin
        if (fimq.size() == 0 || fimq[0] != edge_n) begin
          checks++; errors++;
          $display("FAIL fim_unexpected at edge %0d: got fim=1, expected fim=0", edge_n);
        end else begin
          chk("fim_edge", 32'(fimq.pop_front()), 32'(edge_n));
        end
      end
      if (prev_ok === 1'b1 && edge_n != reset_edge)
        chk("hold_after_ok", 32'({nota, tom}), 32'({prev_nota, prev_tom}));
    end
    prev_ok   = ok;
    prev_nota = nota;
    prev_tom  = tom;
  end

  initial begin
    repeat (3) drive(1'b0, 2'b00, 1'b0, 1'b1);
    idle(2);
    // comp, variante 0
    drive(1'b1, 2'b10, 1'b0, 1'b0);
    idle(25);
    // nulo: three notes only
    drive(1'b1, 2'b00, 1'b0, 1'b0);
    idle(20);
    // adv accepted, tipo changed and start re-pulsed mid-word
    drive(1'b1, 2'b11, 1'b0, 1'b0);
    repeat (6) drive(1'b0, 2'b01, 1'b1, 1'b0);
    drive(1'b1, 2'b01, 1'b1, 1'b0);
    repeat (5) drive(1'b0, 2'b01, 1'b0, 1'b0);
    drive(1'b1, 2'b01, 1'b0, 1'b0);
    idle(20);
    // reset the cycle after the second ok, then a full word
    drive(1'b1, 2'b01, 1'b0, 1'b0);
    idle(8);
    drive(1'b0, 2'b01, 1'b0, 1'b1);
    idle(3);
    drive(1'b1, 2'b01, 1'b1, 1'b0);
    idle(25);
    // start and reset on the same edge
    drive(1'b1, 2'b10, 1'b1, 1'b1);
    idle(3);
    // start held high: back-to-back adj/variante 1 words
    repeat (60) drive(1'b1, 2'b01, 1'b1, 1'b0);
    idle(5);
    // randomized traffic with occasional resets
    repeat (400)
      drive(1'($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) == 0));
    idle(30);
    chk("ok_queue_drained", 32'(okq.size()), 32'd0);
    chk("fim_queue_drained", 32'(fimq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
